fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
- Reader end of the bridge's 8-bit byte FIFO.
- Pops one byte at a time from the FIFO through its read-enable/underflow interface, then serialises it onto the UART TX line as start, 8 data bits LSB-first, optional parity, and stop bit(s).
- Sits between the byte FIFO's output side and the UART pin. It is the only agent that asserts the FIFO read enable.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per UART bit time. Legal range is 2 to 65535.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits. Legal values are 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tx_en  in  1  permits the start of new frames. A frame already in progress always completes.
- fifo_data  in  8  FIFO output byte. Valid on the cycle after fifo_rd is asserted.
- fifo_empty  in  1  FIFO underflow/empty flag. High means there is no byte to pop.
- fifo_rd  out  1  FIFO read enable. Single-cycle pulse.
- tx  out  1  UART serial line. Idles high.
- busy  out  1  high from the fifo_rd cycle through the last stop-bit cycle.
- frame_done  out  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset is synchronous and active-high. On the first edge with reset high:
  - tx = 1, fifo_rd = 0, busy = 0, frame_done = 0.
  - state = IDLE; bit counter = 0; baud counter = 0; shift register = 0.
  - Reset has priority over all other activity.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1.
  - If tx_en = 1 and fifo_empty = 0: fifo_rd = 1 for this cycle only, busy = 1, next state FETCH.
  - Otherwise remain in IDLE with fifo_rd = 0.
- FETCH (exactly 1 cycle):
  - fifo_rd = 0. fifo_data is latched into the shift register on this cycle's edge. Next state START.
  - fifo_empty and tx_en are ignored in FETCH; the pop is already committed.
  - Timing: if fifo_rd is high in cycle N, tx falls at cycle N+2.
- START: tx = 0 for CLKS_PER_BIT cycles.
- DATA:
  - tx = shift register bit 0, held for CLKS_PER_BIT cycles per bit.
  - The register shifts right after each bit.
  - 8 bits are sent, bit 0 first.
  - The bit counter is 3 bits and counts 0..7.
- PARITY:
  - Entered only when PARITY != 0.
  - tx = XOR of the 8 latched bits for even parity, or its inverse for odd parity. Held for CLKS_PER_BIT cycles.
  - Parity is computed from the byte as latched, not from the shifted register.
- STOP:
  - tx = 1 for CLKS_PER_BIT * STOP_BITS cycles.
  - frame_done = 1 on the last of those cycles; busy drops on the following cycle; next state IDLE.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit transition. It never runs free in IDLE or FETCH.
- Back-to-back frames: the minimum tx-high gap between the end of one stop period and the next start bit is 2 cycles (IDLE, FETCH), in addition to the stop bits.
- No second pop is ever issued while busy = 1. Exactly one fifo_rd pulse occurs per frame.
- tx_en falling mid-frame: the frame finishes normally; no new pop follows.
- fifo_empty rising mid-frame: no effect on the frame in progress.
- fifo_empty and tx_en are sampled only in IDLE.
- Reset mid-frame:
  - tx returns high on the next edge; the byte is discarded and is not re-read; no fifo_rd is issued during reset.
  - After reset is released, one IDLE cycle elapses before any new pop.
- tx is driven from a register (glitch-free).
- Frame length in clk cycles is CLKS_PER_BIT * (1 + 8 + (PARITY != 0) + STOP_BITS).

Test Plan:
- CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1. FIFO holds 0xA5; tx_en=1 → one fifo_rd pulse; tx falls 2 cycles later; line shows 0 then 1,0,1,0,0,1,0,1 then 1, each bit 4 cycles (40 cycles total); frame_done pulses at cycle 40; busy clears after it.
- FIFO holds 0x3C and 0xFF → two fifo_rd pulses separated by exactly 42 cycles; tx-high gap between frames is 4 + 2 cycles; second frame bits are all 1s.
- PARITY=1 with byte 0x07 → parity bit 1. PARITY=2 with the same byte → parity bit 0. Frame is 44 cycles.
- fifo_empty=1 with tx_en=1 for 50 cycles → fifo_rd never asserts; tx stays 1; busy stays 0. Deassert fifo_empty → fifo_rd pulses on the next cycle.
- Frame for 0x81 in progress; tx_en=0 at cycle 10 → frame completes intact; no further fifo_rd even though FIFO is not empty.
- Assert reset at cycle 15 of a frame for 1 cycle → on the next edge tx=1, busy=0, frame_done never pulses, no fifo_rd during reset. Re-arm → the next byte from the FIFO is transmitted cleanly.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the byte FIFO and serialises them as UART frames: start, 8 data LSB-first, optional parity, stop.
// tx falls 2 cycles after the fifo_rd pulse; pops only from IDLE when tx_en is high and the FIFO is non-empty.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state, state_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [BW-1:0]   baud_cnt, baud_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    baud_cnt_d = baud_cnt;
    shift_d    = shift_q;
    par_d      = par_q;
    fifo_rd    = 1'b0;
    frame_done = 1'b0;

    // Baud counter only runs while a bit is on the line.
    if (state != S_IDLE && state != S_FETCH) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt + BW'(1);
    end

    case (state)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (tx_en && !fifo_empty && !reset) begin
          fifo_rd = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        shift_d = fifo_data;
        par_d   = (^fifo_data) ^ ODD;
        state_d = S_START;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            frame_done = 1'b1;
            bit_cnt_d  = '0;
            state_d    = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so tx never glitches.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      baud_cnt <= baud_cnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state != S_IDLE) || fifo_rd;

endmodule
